// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared raster timing types, defaults and helpers
package vga_timing_gen_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    localparam axis_timing_t H_640 = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam axis_timing_t V_480 = '{active: 480, fp: 10, sync: 2, bp: 33};

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - video timing output bundle
interface vga_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output hsync, vsync, de, pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, de, pix_x, pix_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with active/sync decode
module vga_axis_counter #(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 751,
    parameter int unsigned W          = 10
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         adv_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam logic [W-1:0] LAST_V   = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_V = W'(ACTIVE);
    localparam logic [W-1:0] SS_V     = W'(SYNC_START);
    localparam logic [W-1:0] SE_V     = W'(SYNC_END);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // wrap is a position flag, not gated by adv; the parent qualifies it.
    assign cnt_o    = cnt_q;
    assign wrap_o   = (cnt_q == LAST_V);
    assign active_o = (cnt_q < ACTIVE_V);
    assign sync_o   = (cnt_q >= SS_V) && (cnt_q <= SE_V);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with registered sync/DE/coordinate outputs
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_640.active,
    parameter int unsigned H_FP     = H_640.fp,
    parameter int unsigned H_SYNC   = H_640.sync,
    parameter int unsigned H_BP     = H_640.bp,
    parameter int unsigned V_ACTIVE = V_480.active,
    parameter int unsigned V_FP     = V_480.fp,
    parameter int unsigned V_SYNC   = V_480.sync,
    parameter int unsigned V_BP     = V_480.bp,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    vga_timing_gen_if.master    vid_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW      = clog2(H_TOTAL);
    localparam int unsigned YW      = clog2(V_TOTAL);

    generate
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
            XW > 16 || YW > 16) begin : g_bad_params
            $error("vga_timing_gen: zero timing parameter or counter wider than 16 bits");
        end
    endgenerate

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC - 1),
        .W          (XW)
    ) u_h (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .adv_i    (en_i),
        .cnt_o    (h_cnt),
        .wrap_o   (h_wrap),
        .active_o (h_act),
        .sync_o   (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC - 1),
        .W          (YW)
    ) u_v (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .adv_i    (en_i && h_wrap),
        .cnt_o    (v_cnt),
        .wrap_o   (v_wrap),
        .active_o (v_act),
        .sync_o   (v_sync)
    );

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    // While frozen, strobes and DE drop but syncs and coordinates keep their last value.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        de_d    = 1'b0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (en_i) begin
            de_d    = h_act && v_act;
            pix_x_d = de_d ? h_cnt : '0;
            pix_y_d = de_d ? v_cnt : '0;
            ls_d    = de_d && (h_cnt == '0);
            fs_d    = (h_cnt == '0) && (v_cnt == '0);
            hsync_d = h_sync ? SYNC_POL : ~SYNC_POL;
            vsync_d = v_sync ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            pix_x_q <= '0;
            pix_y_q <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign vid_o.hsync       = hsync_q;
    assign vid_o.vsync       = vsync_q;
    assign vid_o.de          = de_q;
    assign vid_o.pix_x       = pix_x_q;
    assign vid_o.pix_y       = pix_y_q;
    assign vid_o.line_start  = ls_q;
    assign vid_o.frame_start = fs_q;

    logic unused_wrap;
    assign unused_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench on a reduced 32x12 raster
module tb_vga_timing_gen;

    // Reduced raster: H 20+3+5+4 = 32, V 6+2+3+1 = 12, 384 clocks per frame.
    localparam int unsigned XW = 5;
    localparam int unsigned YW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing_gen_if #(.XW(XW), .YW(YW)) vid ();

    vga_timing_gen #(
        .H_ACTIVE (20), .H_FP (3), .H_SYNC (5), .H_BP (4),
        .V_ACTIVE (6),  .V_FP (2), .V_SYNC (3), .V_BP (1),
        .SYNC_POL (1'b0)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .vid_o   (vid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fs_cnt, ls_cnt, de_cnt, de_late;
        int hs_first, hs_last, hs_cnt, vs_first, vs_last, vs_cnt;
        int px19, de20, ls32, px170, py170;
        int bad_hold, found;

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();
        check("rst_hsync", int'(vid.hsync), 1);
        check("rst_vsync", int'(vid.vsync), 1);
        check("rst_de",    int'(vid.de), 0);
        check("rst_pix_x", int'(vid.pix_x), 0);
        check("rst_pix_y", int'(vid.pix_y), 0);
        check("rst_ls",    int'(vid.line_start), 0);
        check("rst_fs",    int'(vid.frame_start), 0);

        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check("first_fs", int'(vid.frame_start), 1);
        check("first_de", int'(vid.de), 1);
        check("first_ls", int'(vid.line_start), 1);

        fs_cnt = 0; ls_cnt = 0; de_cnt = 0; de_late = 0;
        hs_first = -1; hs_last = -1; hs_cnt = 0;
        vs_first = -1; vs_last = -1; vs_cnt = 0;
        px19 = -1; de20 = -1; ls32 = -1; px170 = -1; py170 = -1;
        for (int k = 0; k < 384; k++) begin
            if (vid.frame_start) fs_cnt++;
            if (vid.line_start)  ls_cnt++;
            if (vid.de)          de_cnt++;
            if (vid.de && k >= 192) de_late++;
            if (k < 32 && !vid.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
                hs_last = k;
            end
            if (!vid.vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
                vs_last = k;
            end
            if (k == 19)  px19 = int'(vid.pix_x);
            if (k == 20)  de20 = int'(vid.de);
            if (k == 32)  ls32 = int'(vid.line_start);
            if (k == 170) begin
                px170 = int'(vid.pix_x);
                py170 = int'(vid.pix_y);
            end
            step();
        end
        check("frame_fs_count",  fs_cnt, 1);
        check("frame_ls_count",  ls_cnt, 6);
        check("frame_de_count",  de_cnt, 120);
        check("de_in_blank",     de_late, 0);
        check("hsync_first",     hs_first, 23);
        check("hsync_last",      hs_last, 27);
        check("hsync_width",     hs_cnt, 5);
        check("vsync_first",     vs_first, 256);
        check("vsync_last",      vs_last, 351);
        check("vsync_width",     vs_cnt, 96);
        check("pix_x_19",        px19, 19);
        check("de_col20",        de20, 0);
        check("line_period",     ls32, 1);
        check("pix_x_k170",      px170, 10);
        check("pix_y_k170",      py170, 5);

        check("wrap_fs",    int'(vid.frame_start), 1);
        check("wrap_de",    int'(vid.de), 1);
        check("wrap_pix_x", int'(vid.pix_x), 0);
        check("wrap_pix_y", int'(vid.pix_y), 0);

        repeat (10) step();
        check("pre_hold_pix_x", int'(vid.pix_x), 10);
        en = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (vid.de !== 1'b0 || vid.pix_x !== 5'd10 || vid.pix_y !== 4'd0 ||
                vid.hsync !== 1'b1 || vid.vsync !== 1'b1 ||
                vid.line_start !== 1'b0 || vid.frame_start !== 1'b0)
                bad_hold++;
        end
        check("hold_outputs", bad_hold, 0);
        en = 1'b1;
        step();
        check("resume_de",    int'(vid.de), 1);
        check("resume_pix_x", int'(vid.pix_x), 11);

        repeat (12) step();
        check("hs_pre_freeze", int'(vid.hsync), 0);
        en = 1'b0;
        repeat (5) step();
        check("hs_frozen_low", int'(vid.hsync), 0);
        check("hs_frozen_de",  int'(vid.de), 0);
        en = 1'b1;
        repeat (4) step();
        check("hs_resume_low",  int'(vid.hsync), 0);
        step();
        check("hs_resume_high", int'(vid.hsync), 1);

        found = 0;
        for (int i = 0; i < 500; i++) begin
            if (vid.de && vid.pix_y == 4'd3) begin
                found = 1;
                break;
            end
            step();
        end
        check("find_row3", found, 1);
        rst_n = 1'b0;
        #1;
        check("async_hsync", int'(vid.hsync), 1);
        check("async_vsync", int'(vid.vsync), 1);
        check("async_de",    int'(vid.de), 0);
        check("async_pix_x", int'(vid.pix_x), 0);
        check("async_pix_y", int'(vid.pix_y), 0);
        #3;
        rst_n = 1'b1;
        step();
        check("restart_fs",    int'(vid.frame_start), 1);
        check("restart_de",    int'(vid.de), 1);
        check("restart_pix_x", int'(vid.pix_x), 0);
        step();
        check("restart_next_x", int'(vid.pix_x), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
